// File: rtl/mem_stage_access.sv
// MEM stage: drives the data-memory bus for loads/stores and feeds the MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops >= 2 cycles (detect, then request with ack), abort after TIMEOUT busy cycles.
// Backpressure: hold stalls EX/MEM and upstream while an access is pending; MEM/WB gets bubbles meanwhile.
// Optional feature macro: ALIGN_CHECK_EN (reject misaligned word accesses with a bus_err pulse).
module mem_stage_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  destReg,
    input  logic        MemWrite,
    input  logic        memtoreg,
    input  logic        regWrite,
    input  logic        is_byte,
    input  logic [31:0] alu_out,
    input  logic [31:0] operand_2,
    output logic        hold,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  wb_destReg,
    output logic        wb_regWrite,
    output logic        wb_memtoreg,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_mem_data,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            mem_op;
    logic            is_load;
    logic            misalign;
    logic            timeout_hit;
    logic            issue;
    logic            complete;
    logic            abort;
    logic            ld_byte_q;
    logic [1:0]      ld_lane_q;
    logic [7:0]      ld_lane_byte;
    logic [31:0]     ld_data;

    assign mem_op      = MemWrite | memtoreg;
    // a store wins over a load when both flags are set
    assign is_load     = memtoreg & ~MemWrite;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

`ifdef ALIGN_CHECK_EN
    assign misalign = ~is_byte & (alu_out[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Next state and stall/error decode; everything is gated by rst so outputs stay 0 in reset
    always_comb begin
        state_nxt = state;
        hold      = 1'b0;
        bus_err   = 1'b0;
        issue     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (misalign) begin
                            bus_err = 1'b1;
                        end else begin
                            hold      = 1'b1;
                            issue     = 1'b1;
                            state_nxt = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else if (timeout_hit) begin
                        abort     = 1'b1;
                        bus_err   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        hold = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Pick the addressed byte lane of the returned word
    always_comb begin
        ld_lane_byte = 8'h00;
        case (ld_lane_q)
            2'd0: ld_lane_byte = mem_rdata[7:0];
            2'd1: ld_lane_byte = mem_rdata[15:8];
            2'd2: ld_lane_byte = mem_rdata[23:16];
            2'd3: ld_lane_byte = mem_rdata[31:24];
            default: ld_lane_byte = 8'h00;
        endcase
    end

    assign ld_data = ld_byte_q ? {24'h0, ld_lane_byte} : mem_rdata;

    // State register and busy-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                cnt <= '0;
            end else if (state == BUSY && !mem_ack) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Bus fields are captured at detect and held stable until the access ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ld_byte_q <= 1'b0;
            ld_lane_q <= '0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {alu_out[31:2], 2'b00};
            mem_be    <= is_byte ? (4'b0001 << alu_out[1:0]) : 4'hF;
            mem_wdata <= is_byte ? {4{operand_2[7:0]}} : operand_2;
            ld_byte_q <= is_byte;
            ld_lane_q <= alu_out[1:0];
        end else if (complete || abort) begin
            mem_req <= 1'b0;
        end
    end

    // MEM/WB register: bubble while stalled or on error, otherwise the (held) EX/MEM inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_destReg  <= '0;
            wb_regWrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_alu_out  <= '0;
            wb_mem_data <= '0;
        end else begin
            wb_destReg <= destReg;
            wb_alu_out <= alu_out;
            if (hold || bus_err) begin
                wb_regWrite <= 1'b0;
                wb_memtoreg <= 1'b0;
                wb_mem_data <= '0;
            end else begin
                wb_regWrite <= regWrite & ~MemWrite;
                wb_memtoreg <= is_load;
                wb_mem_data <= (complete && is_load) ? ld_data : 32'h0;
            end
        end
    end

endmodule
